// File: rtl/cacheline_adaptor_if.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adaptor_if
// Brief    : Cache-side line port and memory-side burst port of the adaptor.
// Revision : 1.0  initial release
// ============================================================================
interface cacheline_adaptor_if;
    // cache side
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    // memory side
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adaptor
// Brief    : Converts 256-bit cache line requests into 4-beat 64-bit bursts.
// Revision : 1.0  initial release
// ============================================================================
module cacheline_adaptor (
    input  wire logic          clk,
    input  wire logic          rst,
    cacheline_adaptor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [31:0] c_ADDR_MASK = 32'hFFFF_FFE0;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_cnt;
    logic [1:0]   w_cnt_nxt;
    logic [255:0] r_line;
    logic [255:0] r_wline;
    logic [31:0]  r_addr;
    logic         w_latch_addr;
    logic         w_latch_wr;
    logic         w_beat_rd;
    logic [7:0]   w_beat_lsb;

    assign w_beat_lsb = {r_cnt, 6'd0};

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_latch_addr = 1'b0;
        w_latch_wr   = 1'b0;
        w_beat_rd    = 1'b0;
        bus.read_o   = 1'b0;
        bus.write_o  = 1'b0;
        bus.resp_o   = 1'b0;
        bus.burst_o  = '0;
        case (r_state)
            IDLE: begin
                // write wins when both requests are raised together
                if (bus.write_i) begin
                    w_latch_addr = 1'b1;
                    w_latch_wr   = 1'b1;
                    w_cnt_nxt    = 2'd0;
                    w_state_nxt  = WR_BURST;
                end else if (bus.read_i) begin
                    w_latch_addr = 1'b1;
                    w_cnt_nxt    = 2'd0;
                    w_state_nxt  = RD_BURST;
                end
            end
            RD_BURST: begin
                bus.read_o = 1'b1;
                if (bus.resp_i) begin
                    w_beat_rd = 1'b1;
                    w_cnt_nxt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            WR_BURST: begin
                bus.write_o = 1'b1;
                bus.burst_o = r_wline[w_beat_lsb +: 64];
                if (bus.resp_i) begin
                    w_cnt_nxt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                bus.resp_o  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
            r_line  <= '0;
            r_wline <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch_addr) begin
                r_addr <= bus.address_i;
            end
            if (w_latch_wr) begin
                r_wline <= bus.line_i;
            end
            if (w_beat_rd) begin
                r_line[w_beat_lsb +: 64] <= bus.burst_i;
            end
        end
    end

    // bursts always start on a 32-byte line boundary
    assign bus.address_o = r_addr & c_ADDR_MASK;
    assign bus.line_o    = r_line;

endmodule
`default_nettype wire

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameters: none; all widths fixed (line 256 b, burst 64 b, address 32 b, 4 beats per line).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 line_i  input  256  line to write, from cache datapath.
REQ-005 line_o  output  256  assembled line returned on read.
REQ-006 address_i  input  32  line address from cache.
REQ-007 read_i  input  1  cache-side line read request (pmem_read).
REQ-008 write_i  input  1  cache-side line write request (pmem_write).
REQ-009 resp_o  output  1  cache-side completion (pmem_resp), one-cycle pulse.
REQ-010 burst_i  input  64  memory read beat data.
REQ-011 burst_o  output  64  memory write beat data.
REQ-012 address_o  output  32  memory burst address.
REQ-013 read_o  output  1  memory burst read request.
REQ-014 write_o  output  1  memory burst write request.
REQ-015 resp_i  input  1  memory beat strobe; one beat transferred per cycle it is high.

Function
REQ-016 FSM states SHALL be exactly IDLE, RD_BURST, WR_BURST, DONE; 2-bit beat counter cnt.
REQ-017 IDLE: write_i=1 -> latch line_i, address_i; cnt=0; go WR_BURST (write has priority if read_i and write_i both high).
REQ-018 IDLE: read_i=1, write_i=0 -> latch address_i; cnt=0; go RD_BURST.
REQ-019 IDLE: resp_i ignored; read_o=write_o=resp_o=0.
REQ-020 address_o SHALL equal latched address with bits [4:0] forced to 0, stable for entire burst.
REQ-021 RD_BURST: read_o=1 combinationally from state; each cycle resp_i=1 -> line buffer bits [64*cnt +: 64] <= burst_i, cnt <= cnt+1.
REQ-022 RD_BURST: resp_i=1 with cnt=3 -> go DONE; resp_i=0 cycles (wait states, before or between beats) hold state and cnt.
REQ-023 WR_BURST: write_o=1; burst_o = latched line [64*cnt +: 64]; each resp_i=1 advances cnt; resp_i=1 with cnt=3 -> go DONE.
REQ-024 burst_o SHALL be 0 outside WR_BURST.
REQ-025 DONE: resp_o=1 for exactly one cycle, read_o=write_o=0; unconditionally return to IDLE.
REQ-026 line_o SHALL be the line buffer register; valid in DONE after a read; held unchanged until next read beat or reset.
REQ-027 read_i/write_i changes outside IDLE SHALL be ignored; burst completes regardless.
REQ-028 Latency, zero memory wait: request sampled edge T0; read_o/write_o high T0+1..T0+4 (beats on resp_i T0+1..T0+4); resp_o high T0+5; back in IDLE T0+6 (new request accepted at edge ending T0+6).
REQ-029 cnt wrap 3->0 SHALL occur only on transition to DONE; no fifth beat ever consumed.

Reset
REQ-030 rst=1 at an edge SHALL force state IDLE, cnt=0, line buffer and latched address/line to 0, regardless of state.
REQ-031 After reset: resp_o=0, read_o=0, write_o=0, burst_o=0, address_o=0, line_o=0.
REQ-032 Reset mid-burst SHALL abandon the burst with no resp_o pulse; beats arriving after reset ignored.

Verification
REQ-033 Read, no waits: address_i=0x0000_1234, read_i=1; burst_i=0x11..11,0x22..22,0x33..33,0x44..44 on 4 resp_i cycles -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o one cycle at T0+5.
REQ-034 Write with waits: line_i={0xD..,0xC..,0xB..,0xA..}, write_i=1; resp_i pattern 0,0,1,0,1,1,1 -> burst_o steps A,B,C,D only on resp_i=1 edges, write_o high 7 cycles, single resp_o after.
REQ-035 read_i=write_i=1 in IDLE -> write burst performed, read_o never asserted.
REQ-036 rst=1 after 2 read beats -> next cycle all outputs 0, line_o=0; subsequent resp_i pulses produce no resp_o.
REQ-037 Back-to-back: read then write, request held high through resp_o -> second burst starts only after IDLE cycle; resp_i in IDLE ignored, no spurious resp_o.
